// File: rtl/fib_bus_master.sv
// Host-side initiator for the fib accelerator's shared 8-bit register bus:
// writes a seed pair, starts the accelerator, waits for it, and reads the pair back.
module fib_bus_master #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_seed_a,
  input  logic [7:0]       cmd_seed_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_a,
  output logic [7:0]       res_b,
  output logic [CNT_W-1:0] res_busy_cycles,
  output logic             res_timeout,
  inout  wire  [7:0]       bus_data,
  output logic             bus_address,
  output logic             bus_we,
  output logic             bus_oe,
  output logic             bus_start,
  input  logic             bus_busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    START,
    WAIT_HI,
    WAIT_LO,
    RD_A,
    RD_B,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       seed_a_q, seed_a_d;
  logic [7:0]       seed_b_q, seed_b_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]       res_a_q, res_a_d;
  logic [7:0]       res_b_q, res_b_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      seed_a_q   <= '0;
      seed_b_q   <= '0;
      tmo_q      <= '0;
      res_a_q    <= '0;
      res_b_q    <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_a_q   <= seed_a_d;
      seed_b_q   <= seed_b_d;
      tmo_q      <= tmo_d;
      res_a_q    <= res_a_d;
      res_b_q    <= res_b_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Bus strobes depend only on the registered state, so reset releases them at once.
  assign bus_we      = (state_q == WR_A) || (state_q == WR_B);
  assign bus_oe      = (state_q == RD_A) || (state_q == RD_B);
  assign bus_start   = (state_q == START);
  assign bus_address = (state_q == WR_B) || (state_q == RD_B);
  assign bus_data    = bus_we ? (bus_address ? seed_b_q : seed_a_q) : {8{1'bz}};

  assign cmd_ready       = (state_q == IDLE) && !bus_busy;
  assign res_valid       = (state_q == DONE);
  assign res_a           = res_a_q;
  assign res_b           = res_b_q;
  assign res_busy_cycles = busy_cnt_q;
  assign res_timeout     = timeout_q;

  always_comb begin
    state_d    = state_q;
    seed_a_d   = seed_a_q;
    seed_b_d   = seed_b_q;
    tmo_d      = tmo_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          seed_a_d   = cmd_seed_a;
          seed_b_d   = cmd_seed_b;
          tmo_d      = '0;
          res_a_d    = '0;
          res_b_d    = '0;
          busy_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = WR_A;
        end
      end
      WR_A:  state_d = WR_B;
      WR_B:  state_d = START;
      START: state_d = WAIT_HI;
      WAIT_HI, WAIT_LO: begin
        tmo_d = tmo_q + TO_W'(1);
        if (bus_busy && (busy_cnt_q != '1)) begin
          busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end
        // Timeout wins over a busy edge landing on the same cycle.
        if (tmo_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (state_q == WAIT_HI) begin
          if (bus_busy) state_d = WAIT_LO;
        end else if (!bus_busy) begin
          state_d = RD_A;
        end
      end
      RD_A: begin
        res_a_d = bus_data;
        state_d = RD_B;
      end
      RD_B: begin
        res_b_d = bus_data;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
